// File: rtl/lfsr_if.sv
// Control and observation bundle for lfsr_gen: step/load requests in,
// state and period-measurement flags out.
interface lfsr_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             lockup;
    logic             period_done;
    logic [WIDTH-1:0] period_len;

    modport master (
        output en, load, seed,
        input  q, serial_out, lockup, period_done, period_len
    );

    modport slave (
        input  en, load, seed,
        output q, serial_out, lockup, period_done, period_len
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, all-zero lockup recovery
// and measurement of the step count between returns to the start value.
module lfsr_gen #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1000,
    parameter int               MODE         = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 'd1
) (
    input  logic  clk,
    input  logic  rst_n,
    lfsr_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_len_q, period_len_d;
    logic             lockup_q, lockup_d;
    logic             period_done_q, period_done_d;

    logic [WIDTH-1:0] step_fib;
    logic [WIDTH-1:0] step_gal;
    logic [WIDTH-1:0] step_nxt;
    logic [WIDTH-1:0] cnt_inc;

    assign step_fib = {q_q[WIDTH-2:0], ^(q_q & TAPS)};

    // Galois: the MSB rotates into bit 0 and is folded into every tapped bit.
    assign step_gal[0] = q_q[WIDTH-1];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_galois
            assign step_gal[gi] = q_q[gi-1] ^ (TAPS[gi] & q_q[WIDTH-1]);
        end
    endgenerate

    assign step_nxt = (MODE != 0) ? step_gal : step_fib;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        q_d           = q_q;
        start_d       = start_q;
        cnt_d         = cnt_q;
        period_len_d  = period_len_q;
        lockup_d      = 1'b0;
        period_done_d = 1'b0;
        if (bus.load) begin
            if (bus.seed == '0) begin
                q_d      = SEED_DEFAULT;
                start_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
            end else begin
                q_d     = bus.seed;
                start_d = bus.seed;
            end
            cnt_d = '0;
        end else if (bus.en) begin
            if (q_q == '0) begin
                q_d      = SEED_DEFAULT;
                start_d  = SEED_DEFAULT;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else begin
                q_d = step_nxt;
                if (step_nxt == start_q) begin
                    period_done_d = 1'b1;
                    period_len_d  = cnt_inc;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q           <= SEED_DEFAULT;
            start_q       <= SEED_DEFAULT;
            cnt_q         <= '0;
            period_len_q  <= '0;
            lockup_q      <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            q_q           <= q_d;
            start_q       <= start_d;
            cnt_q         <= cnt_d;
            period_len_q  <= period_len_d;
            lockup_q      <= lockup_d;
            period_done_q <= period_done_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.serial_out  = q_q[WIDTH-1];
    assign bus.lockup      = lockup_q;
    assign bus.period_done = period_done_q;
    assign bus.period_len  = period_len_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Drives four lfsr_gen configurations with shared stimulus and checks each
// against a behavioural model, plus literal sequences for the known cases.
module tb_lfsr_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed = 4'h0;
    bit         chk_en = 1'b0;
    int         tests = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    lfsr_if #(.WIDTH(4)) if0 ();
    lfsr_if #(.WIDTH(4)) if1 ();
    lfsr_if #(.WIDTH(4)) if2 ();
    lfsr_if #(.WIDTH(4)) if3 ();

    assign if0.en = en; assign if0.load = load; assign if0.seed = seed;
    assign if1.en = en; assign if1.load = load; assign if1.seed = seed;
    assign if2.en = en; assign if2.load = load; assign if2.seed = seed;
    assign if3.en = en; assign if3.load = load; assign if3.seed = seed;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1000), .MODE(1), .SEED_DEFAULT(4'd1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .SEED_DEFAULT(4'd1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .MODE(1), .SEED_DEFAULT(4'd1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .MODE(0), .SEED_DEFAULT(4'd1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic [3:0] d_q [4];
    logic       d_ser [4];
    logic       d_lock [4];
    logic       d_pd [4];
    logic [3:0] d_plen [4];

    assign d_q[0] = if0.q; assign d_ser[0] = if0.serial_out; assign d_lock[0] = if0.lockup;
    assign d_pd[0] = if0.period_done; assign d_plen[0] = if0.period_len;
    assign d_q[1] = if1.q; assign d_ser[1] = if1.serial_out; assign d_lock[1] = if1.lockup;
    assign d_pd[1] = if1.period_done; assign d_plen[1] = if1.period_len;
    assign d_q[2] = if2.q; assign d_ser[2] = if2.serial_out; assign d_lock[2] = if2.lockup;
    assign d_pd[2] = if2.period_done; assign d_plen[2] = if2.period_len;
    assign d_q[3] = if3.q; assign d_ser[3] = if3.serial_out; assign d_lock[3] = if3.lockup;
    assign d_pd[3] = if3.period_done; assign d_plen[3] = if3.period_len;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // One LFSR step from the written rules, per configuration index.
    function automatic logic [3:0] next_of(input int k, input logic [3:0] v);
        logic [3:0] taps;
        bit         galois;
        logic       par;
        case (k)
            0:       begin taps = 4'b1000; galois = 1'b1; end
            1:       begin taps = 4'b1100; galois = 1'b0; end
            2:       begin taps = 4'b0000; galois = 1'b1; end
            default: begin taps = 4'b0000; galois = 1'b0; end
        endcase
        if (galois)
            return {v[2:0], v[3]} ^ (v[3] ? {taps[3:1], 1'b0} : 4'h0);
        par = ($countones(v & taps) % 2) == 1;
        return {v[2:0], par};
    endfunction

    logic [3:0] m_q [4];
    logic [3:0] m_start [4];
    logic [3:0] m_cnt [4];
    logic [3:0] m_plen [4];
    logic       m_lock [4];
    logic       m_pd [4];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            logic [3:0] n;
            logic [3:0] c;
            if (!rst_n) begin
                m_q[k] <= 4'd1; m_start[k] <= 4'd1; m_cnt[k] <= 4'd0;
                m_plen[k] <= 4'd0; m_lock[k] <= 1'b0; m_pd[k] <= 1'b0;
            end else begin
                m_lock[k] <= 1'b0;
                m_pd[k]   <= 1'b0;
                if (load) begin
                    n = (seed == 4'd0) ? 4'd1 : seed;
                    m_q[k] <= n; m_start[k] <= n; m_cnt[k] <= 4'd0;
                    m_lock[k] <= (seed == 4'd0);
                end else if (en) begin
                    if (m_q[k] == 4'd0) begin
                        m_q[k] <= 4'd1; m_start[k] <= 4'd1; m_cnt[k] <= 4'd0;
                        m_lock[k] <= 1'b1;
                    end else begin
                        n = next_of(k, m_q[k]);
                        c = m_cnt[k] + 4'd1;
                        m_q[k] <= n;
                        if (n == m_start[k]) begin
                            m_pd[k] <= 1'b1; m_plen[k] <= c; m_cnt[k] <= 4'd0;
                        end else begin
                            m_cnt[k] <= c;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("q[%0d]", k), 32'(d_q[k]), 32'(m_q[k]));
                chk($sformatf("serial_out[%0d]", k), 32'(d_ser[k]), 32'(m_q[k][3]));
                chk($sformatf("lockup[%0d]", k), 32'(d_lock[k]), 32'(m_lock[k]));
                chk($sformatf("period_done[%0d]", k), 32'(d_pd[k]), 32'(m_pd[k]));
                chk($sformatf("period_len[%0d]", k), 32'(d_plen[k]), 32'(m_plen[k]));
            end
        end
    end

    // Apply inputs at a falling edge; return at the next falling edge.
    task automatic drive(input logic e, input logic l, input logic [3:0] s);
        en = e; load = l; seed = s;
        @(negedge clk);
    endtask

    logic [3:0] t1 [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011, 4'b1111, 4'b0111};
    logic [3:0] t2 [6] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_q[%0d]", k), 32'(d_q[k]), 32'd1);
            chk($sformatf("rst_flags[%0d]", k), 32'({d_lock[k], d_pd[k]}), 32'd0);
            chk($sformatf("rst_plen[%0d]", k), 32'(d_plen[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // T1/T2: maximal sequences from 0001
        drive(1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 4'h0);
            if (i < 7) chk($sformatf("t1_q%0d", i), 32'(if0.q), 32'(t1[i]));
            if (i < 6) chk($sformatf("t2_q%0d", i), 32'(if1.q), 32'(t2[i]));
            if (i < 14) chk("t1_no_pd", 32'(if0.period_done), 32'd0);
        end
        chk("t1_pd", 32'(if0.period_done), 32'd1);
        chk("t1_plen", 32'(if0.period_len), 32'd15);
        chk("t2_pd", 32'(if1.period_done), 32'd1);
        chk("t2_plen", 32'(if1.period_len), 32'd15);
        drive(1'b0, 1'b0, 4'h0);
        chk("t1_pd_clear", 32'(if0.period_done), 32'd0);

        // T3: zero seed
        drive(1'b0, 1'b1, 4'b0000);
        chk("t3_q", 32'(if0.q), 32'd1);
        chk("t3_lock", 32'(if0.lockup), 32'd1);
        drive(1'b0, 1'b0, 4'h0);
        chk("t3_lock_clear", 32'(if0.lockup), 32'd0);

        // T4: degenerate taps
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b1, 1'b0, 4'h0);
        chk("t4_gal_q1", 32'(if2.q), 32'b0001);
        chk("t4_fib_zero", 32'(if3.q), 32'b0000);
        drive(1'b1, 1'b0, 4'h0);
        chk("t4_fib_recover", 32'(if3.q), 32'b0001);
        chk("t4_fib_lock", 32'(if3.lockup), 32'd1);
        drive(1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h0);
        chk("t4_gal_q4", 32'(if2.q), 32'b1000);
        chk("t4_gal_pd", 32'(if2.period_done), 32'd1);
        chk("t4_gal_plen", 32'(if2.period_len), 32'd4);

        // T5: hold on en=0, load beats en
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'h0);
        chk("t5_hold1", 32'(if0.q), 32'b0010);
        drive(1'b0, 1'b0, 4'h0);
        chk("t5_hold2", 32'(if0.q), 32'b0010);
        drive(1'b1, 1'b0, 4'h0);
        chk("t5_resume", 32'(if0.q), 32'b0100);
        drive(1'b1, 1'b1, 4'b0101);
        chk("t5_load_wins", 32'(if0.q), 32'b0101);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h0);
        chk("t5_cnt_cleared", 32'(if0.period_len), 32'd15);
        chk("t5_pd", 32'(if0.period_done), 32'd1);

        // load on the wrap cycle suppresses period_done
        drive(1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 4'b0001);
        chk("wrap_load_q", 32'(if2.q), 32'b0001);
        chk("wrap_load_no_pd", 32'(if2.period_done), 32'd0);

        // T6: asynchronous reset between edges
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_q", 32'(if0.q), 32'd1);
        chk("t6_flags", 32'({if0.lockup, if0.period_done}), 32'd0);
        chk("t6_plen", 32'(if0.period_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 4'h0);
        chk("t6_restart", 32'(if0.q), 32'(t1[0]));

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  4'($urandom_range(0, 15)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
